delay_arbiter: RTL and testbench
================================

DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter: INIT_LAST, default 1'b1, round-robin pointer value after reset (1 = requester 0 wins the first tie).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: req  input  2  per-requester delay request, level; held until that requester's done.
REQ-005 Port: len0  input  4  delay length for requester 0, sampled in LOAD.
REQ-006 Port: len1  input  4  delay length for requester 1, sampled in LOAD.
REQ-007 Port: grant  output  2  one-hot owner of the shared counter; 2'b00 when idle.
REQ-008 Port: done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 Port: busy  output  1  high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-011 Transition IDLE->LOAD SHALL occur when req != 0; the arbitration winner is registered into grant on the same edge.
REQ-012 Arbitration SHALL be: a single request wins; on req=2'b11 the requester other than last SHALL win.
REQ-013 In LOAD, the block SHALL drive the counter load with 4'd15 - len_g (g = granted index), then go to RUN.
REQ-014 In RUN, the block SHALL hold load low (count +1 per cycle) and go to DONE in the cycle count==4'hF.
REQ-015 In DONE, done[g] SHALL be 1 for exactly one cycle; next edge: grant<=0, last<=g, state<=IDLE.
REQ-016 Latency: req first seen in IDLE at cycle T SHALL give done[g] high in cycle T+3+len.
REQ-017 len=0 SHALL give count==15 on the first RUN cycle; done SHALL be at T+3.
REQ-018 len=15 SHALL load 0; done SHALL be at T+18.
REQ-019 req deasserted while granted SHALL be ignored; the operation SHALL complete and done SHALL still pulse.
REQ-020 A new request SHALL be accepted no earlier than the IDLE cycle following DONE (one idle bubble minimum).
REQ-021 Counter wrap from 15 to 0 after DONE or during IDLE SHALL have no effect.
REQ-022 Changes to len0/len1 outside LOAD SHALL have no effect on the running operation.

Reset
REQ-023 On reset_n low, the block SHALL immediately set: state=IDLE, grant=0, done=0, busy=0, last=INIT_LAST, counter=0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-025 After reset release, req SHALL be arbitrated on the first rising edge.

Configuration
REQ-026 Macro DELAY_ARBITER_ABORT_EN defined SHALL add port abort (input, 1 bit).
REQ-027 With the macro defined, abort high in LOAD or RUN SHALL cause: next edge state=IDLE, grant=0, last=g, no done pulse.
REQ-028 With the macro defined, abort SHALL be ignored in IDLE and DONE.
REQ-029 Without the macro, the abort port and its logic SHALL be absent and the behaviour SHALL be as REQ-010..022.

Structure
REQ-030 Package delay_arbiter_pkg SHALL hold the state enum typedef, N_REQ=2 and CNT_MAX=4'hF.
REQ-031 The shared counter SHALL be one instance of counter_4bit (loadable 4-bit up-counter, async active-low reset), driven by this FSM's load/load_data.
REQ-032 No other sub-module SHALL be used.

Verification
REQ-033 Scenario: req=01, len0=3 from idle at cycle T -> grant=01 at T+1; done=01 at T+6; grant=00 at T+7.
REQ-034 Scenario: req=11 after reset (INIT_LAST=1) -> requester 0 served first; requester 1 granted at the IDLE after done[0]; then requester 0 served again.
REQ-035 Scenario: len=0 -> done at T+3; len=15 -> done at T+18; exactly one done pulse each.
REQ-036 Scenario: reset_n pulsed low in RUN with len1=9 -> grant, done and busy 0 immediately; no done pulse afterwards.
REQ-037 Scenario (DELAY_ARBITER_ABORT_EN): abort at RUN cycle 2 with len0=10 -> IDLE next edge, no done; pending req1 granted next.
REQ-038 Scenario: req0 dropped and len0 changed 7->2 during RUN -> done still arrives at T+10.

Source files
------------

// File: rtl/delay_arbiter_pkg.sv
// Shared types and constants for the two-requester delay arbiter.
package delay_arbiter_pkg;

    localparam int         N_REQ   = 2;
    localparam logic [3:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // One-hot winner; on a tie the requester that was not served last wins.
    function automatic logic [N_REQ-1:0] arb_pick(input logic [N_REQ-1:0] req,
                                                  input logic             last);
        logic [N_REQ-1:0] win;
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
        return win;
    endfunction

endpackage

// File: rtl/delay_arbiter_counter.sv
// Loadable 4-bit free-running up-counter; load has priority over increment.
module counter_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_data_i,
    output logic [3:0] count_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_data_i;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter granting a shared delay counter; done pulses len+3 cycles after request
// acceptance, no backpressure (req is level-held). Optional abort input under DELAY_ARBITER_ABORT_EN.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter logic INIT_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
`ifdef DELAY_ARBITER_ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q,  last_d;
    logic       load;
    logic [3:0] load_data;
    logic [3:0] count;
    logic       g_idx;
    logic [3:0] len_g;
    logic       abort_w;

    assign g_idx = grant_q[1];
    assign len_g = g_idx ? len1 : len0;

`ifdef DELAY_ARBITER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= INIT_LAST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        load      = 1'b0;
        load_data = CNT_MAX - len_g;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = LOAD;
                    grant_d = arb_pick(req, last_q);
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (count == CNT_MAX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                last_d  = g_idx;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
        // Abort drops the operation silently but still counts as this requester's turn.
        if (abort_w && (state_q == LOAD || state_q == RUN)) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = g_idx;
        end
    end

    counter_4bit u_counter (
        .clk         (clk),
        .rst_n       (reset_n),
        .load_i      (load),
        .load_data_i (load_data),
        .count_o     (count)
    );

    assign grant = grant_q;
    assign done  = (state_q == DONE) ? grant_q : 2'b00;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed scenarios with literal expectations plus randomized traffic vs a cycle-count model.
module tb_delay_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [3:0] len0, len1;
`ifdef DELAY_ARBITER_ABORT_EN
    logic       abort;
`endif
    logic [1:0] grant, done;
    logic       busy;

    always #5 clk = ~clk;

    delay_arbiter #(.INIT_LAST(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
`ifdef DELAY_ARBITER_ABORT_EN
        .abort   (abort),
`endif
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: an operation accepted in IDLE cycle A owns the counter for cycles A+1..A+3+len,
    // with done in the last of them; len is whatever len_g held in cycle A+1.
    int  cyc    = 0;
    bit  m_busy = 1'b0;
    bit  m_last = 1'b1;
    int  m_g    = 0;
    int  m_acc  = 0;
    int  m_len  = 99;
    bit  m_ab;

    always @(posedge clk) begin
        m_ab = 1'b0;
`ifdef DELAY_ARBITER_ABORT_EN
        m_ab = (abort === 1'b1);
`endif
        if (reset_n !== 1'b1) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            if (cyc == m_acc + 1) m_len = (m_g == 1) ? int'(len1) : int'(len0);
            if (m_ab && cyc >= m_acc + 1 && cyc <= m_acc + 2 + m_len) begin
                m_busy = 1'b0;
                m_last = (m_g == 1);
            end else if (cyc == m_acc + 3 + m_len) begin
                m_busy = 1'b0;
                m_last = (m_g == 1);
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_g = m_last ? 0 : 1;
            else              m_g = (req == 2'b10) ? 1 : 0;
            m_acc  = cyc;
            m_len  = 99;
            m_busy = 1'b1;
        end
        cyc++;
    end

    logic [1:0] e_grant, e_done;
    logic       e_busy;

    always @(negedge clk) begin
        e_grant = 2'b00;
        e_done  = 2'b00;
        e_busy  = 1'b0;
        if (reset_n === 1'b1 && m_busy) begin
            e_grant = (m_g == 1) ? 2'b10 : 2'b01;
            e_busy  = 1'b1;
            if (cyc == m_acc + 3 + m_len) e_done = e_grant;
        end
        chk("mdl_grant", {2'b00, grant}, {2'b00, e_grant});
        chk("mdl_done",  {2'b00, done},  {2'b00, e_done});
        chk("mdl_busy",  {3'b000, busy}, {3'b000, e_busy});
    end

    task automatic do_reset();
        req     = 2'b00;
        reset_n = 1'b0;
        #2;
        chk("rst_grant", {2'b00, grant}, 4'h0);
        chk("rst_done",  {2'b00, done},  4'h0);
        chk("rst_busy",  {3'b000, busy}, 4'h0);
        go(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req     = 2'b00;
        len0    = 4'd0;
        len1    = 4'd0;
`ifdef DELAY_ARBITER_ABORT_EN
        abort   = 1'b0;
`endif
        go(2);
        do_reset();

        // req=01 len0=3 accepted in cycle T
        req = 2'b01; len0 = 4'd3;
        go(1); chk("s1_grant_T1", {2'b00, grant}, 4'h1);
               chk("s1_busy_T1",  {3'b000, busy}, 4'h1);
        go(4); chk("s1_done_T5",  {2'b00, done},  4'h0);
        go(1); chk("s1_done_T6",  {2'b00, done},  4'h1);
        req = 2'b00;
        go(1); chk("s1_grant_T7", {2'b00, grant}, 4'h0);
               chk("s1_busy_T7",  {3'b000, busy}, 4'h0);

        // Tie held: 0, then 1, then 0 again
        do_reset();
        req = 2'b11; len0 = 4'd1; len1 = 4'd2;
        go(1); chk("s2_grant0",  {2'b00, grant}, 4'h1);
        go(3); chk("s2_done0",   {2'b00, done},  4'h1);
        go(1); chk("s2_bubble",  {3'b000, busy}, 4'h0);
        go(1); chk("s2_grant1",  {2'b00, grant}, 4'h2);
        go(4); chk("s2_done1",   {2'b00, done},  4'h2);
        go(2); chk("s2_grant0b", {2'b00, grant}, 4'h1);
        req = 2'b00;
        go(3); chk("s2_done0b",  {2'b00, done},  4'h1);
        go(1); chk("s2_idle",    {3'b000, busy}, 4'h0);

        // len=0 and len=15 boundaries
        do_reset();
        req = 2'b01; len0 = 4'd0;
        go(2); chk("s3_len0_T2", {2'b00, done}, 4'h0);
        go(1); chk("s3_len0_T3", {2'b00, done}, 4'h1);
        req = 2'b00;
        go(1); chk("s3_len0_T4", {2'b00, done}, 4'h0);
        go(1);
        req = 2'b10; len1 = 4'd15;
        go(17); chk("s3_len15_T17", {2'b00, done}, 4'h0);
        go(1);  chk("s3_len15_T18", {2'b00, done}, 4'h2);
        req = 2'b00;
        go(1);  chk("s3_len15_T19", {2'b00, done}, 4'h0);

        // req dropped and len changed mid-run
        do_reset();
        req = 2'b01; len0 = 4'd7;
        go(2); req = 2'b00; len0 = 4'd2;
        go(7); chk("s4_T9",  {2'b00, done}, 4'h0);
        go(1); chk("s4_T10", {2'b00, done}, 4'h1);

        // Reset in RUN aborts without a done pulse
        do_reset();
        req = 2'b10; len1 = 4'd9;
        go(4); chk("s5_run_busy", {3'b000, busy}, 4'h1);
        #2; reset_n = 1'b0; #1;
        chk("s5_rst_grant", {2'b00, grant}, 4'h0);
        chk("s5_rst_done",  {2'b00, done},  4'h0);
        chk("s5_rst_busy",  {3'b000, busy}, 4'h0);
        req = 2'b00;
        go(1); reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            go(1); chk("s5_no_done", {2'b00, done}, 4'h0);
        end

`ifdef DELAY_ARBITER_ABORT_EN
        // Abort in RUN cycle 2; pending requester 1 served next
        do_reset();
        req = 2'b11; len0 = 4'd10; len1 = 4'd1;
        go(1); chk("s6_grant0", {2'b00, grant}, 4'h1);
        go(2); abort = 1'b1;
        go(1); abort = 1'b0;
        chk("s6_ab_grant", {2'b00, grant}, 4'h0);
        chk("s6_ab_done",  {2'b00, done},  4'h0);
        chk("s6_ab_busy",  {3'b000, busy}, 4'h0);
        go(1); chk("s6_grant1", {2'b00, grant}, 4'h2);
        req = 2'b00;
        go(3); chk("s6_done1",  {2'b00, done},  4'h2);
`endif

        // Randomized traffic checked by the model every cycle
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            go(1);
            reset_n = 1'b1;
            if ($urandom_range(0, 5) == 0) req = 2'($urandom_range(0, 3));
            len0 = 4'($urandom);
            len1 = 4'($urandom);
`ifdef DELAY_ARBITER_ABORT_EN
            abort = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 249) == 0) begin
                #2;
                reset_n = 1'b0;
            end
        end
        go(1);
        reset_n = 1'b1;
`ifdef DELAY_ARBITER_ABORT_EN
        abort = 1'b0;
`endif
        req = 2'b00;
        go(25);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
